// File: rtl/fp24_div_pkg.sv
// Shared fp24 math definitions: the fp24 field layout and format constants.
package fp24_div_pkg;

    localparam int         FP24_BIAS    = 63;
    localparam logic [6:0] FP24_EXP_MAX = 7'h7F;
    localparam int         FP24_MANT_W  = 16;

    typedef struct packed {
        logic                   sign;
        logic [6:0]             exp;
        logic [FP24_MANT_W-1:0] mant;
    } fp24_t;

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division step: trial-subtract the divisor and keep
// the difference only when it does not go negative.
module udiv_step #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // Trial subtraction; restore the old remainder when the divisor does not fit.
    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = (rem_in >= {1'b0, divisor});
        rem_out = q_bit ? diff : rem_in;
    end

endmodule

// File: rtl/fp24_div.sv
// Multi-cycle fp24 divider: restoring mantissa division, one quotient bit per
// cycle, behind a valid/ready handshake with one operation in flight.
module fp24_div
    import fp24_div_pkg::*;
#(
    parameter int QBITS       = 18,
    parameter bit FLUSH_UNDER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] quot,
    output logic        div_zero,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [17:0]        rem_q, rem_d;
    logic [QBITS-1:0]   q_q, q_d;
    logic [16:0]        divisor_q, divisor_d;
    logic signed [8:0]  exp_diff_q, exp_diff_d;
    logic               sign_q, sign_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [23:0]        quot_q, quot_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;

    fp24_t              a_f, b_f;
    logic [17:0]        rem_step;
    logic               q_bit;
    logic signed [8:0]  e_norm;
    logic [FP24_MANT_W-1:0] mant_norm;

    assign a_f = a;
    assign b_f = b;

    udiv_step #(.WIDTH(17)) u_step (
        .rem_in  (rem_q),
        .divisor (divisor_q),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    // Next-state, datapath and result logic for the IDLE/DIV/NORM/DONE sequence.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        q_d        = q_q;
        divisor_d  = divisor_q;
        exp_diff_d = exp_diff_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        e_norm     = '0;
        mant_norm  = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    sign_d     = a_f.sign ^ b_f.sign;
                    if (b_f.exp == 7'd0) begin
                        quot_d     = {a_f.sign ^ b_f.sign, FP24_EXP_MAX, 16'h0000};
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else if (a_f.exp == 7'd0) begin
                        quot_d  = {a_f.sign ^ b_f.sign, 23'h0};
                        state_d = DONE;
                    end else begin
                        rem_d      = {1'b0, 1'b1, a_f.mant};
                        divisor_d  = {1'b1, b_f.mant};
                        q_d        = '0;
                        cnt_d      = 5'(QBITS - 1);
                        exp_diff_d = {2'b00, a_f.exp} - {2'b00, b_f.exp} + 9'(FP24_BIAS);
                        state_d    = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = rem_step << 1;
                q_d   = {q_q[QBITS-2:0], q_bit};
                if (cnt_q == 5'd0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            NORM: begin
                // Quotient lies in [0.5, 2): the top bit decides the one-place normalise.
                e_norm = exp_diff_q - {8'd0, ~q_q[QBITS-1]};
                mant_norm = q_q[QBITS-1] ? q_q[QBITS-2 -: FP24_MANT_W]
                                         : q_q[QBITS-3 -: FP24_MANT_W];
                if (e_norm >= 9'sd127) begin
                    quot_d = {sign_q, FP24_EXP_MAX, 16'hFFFF};
                    ovf_d  = 1'b1;
                end else if (e_norm <= 9'sd0) begin
                    quot_d = FLUSH_UNDER ? {sign_q, 23'h0} : {sign_q, 7'd1, 16'h0000};
                end else begin
                    quot_d = {sign_q, e_norm[6:0], mant_norm};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            rem_q      <= '0;
            q_q        <= '0;
            divisor_q  <= '0;
            exp_diff_q <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            quot_q     <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            divisor_q  <= divisor_d;
            exp_diff_q <= exp_diff_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign quot      = quot_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp24_div.sv
// Self-checking bench for fp24_div: reference model feeds a scoreboard queue at
// drive time; each test task pops and compares when the result appears.
module tb_fp24_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] quot;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] q;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp24_div #(.QBITS(18), .FLUSH_UNDER(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact integer quotient of the 1.16 significands, truncated to 1.17.
    function automatic exp_t model(input logic [23:0] av, input logic [23:0] bv);
        exp_t        r;
        logic        s;
        logic [33:0] num;
        logic [33:0] den;
        logic [33:0] qq;
        logic [15:0] m;
        int          e;
        s = av[23] ^ bv[23];
        r.dz = 1'b0;
        r.ov = 1'b0;
        r.lat = 1;
        if (bv[22:16] == 7'd0) begin
            r.q = {s, 7'h7F, 16'h0000};
            r.dz = 1'b1;
        end else if (av[22:16] == 7'd0) begin
            r.q = {s, 23'h0};
        end else begin
            r.lat = 20;
            num = {1'b1, av[15:0], 17'h0};
            den = {17'h0, 1'b1, bv[15:0]};
            qq = num / den;
            e = int'(av[22:16]) - int'(bv[22:16]) + 63;
            if (qq[17]) begin
                m = qq[16:1];
            end else begin
                m = qq[15:0];
                e = e - 1;
            end
            if (e >= 127) begin
                r.q = {s, 7'h7F, 16'hFFFF};
                r.ov = 1'b1;
            end else if (e <= 0) begin
                r.q = {s, 23'h0};
            end else begin
                r.q = {s, 7'(e), m};
            end
        end
        return r;
    endfunction

    task automatic drive_op(input logic [23:0] av, input logic [23:0] bv);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) begin
            errors++;
            $display("FAIL drive_timeout: in_ready=%b required 1", in_ready);
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        sb.push_back(model(av, bv));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (quot !== 24'h0) begin errors++; $display("FAIL rst_quot: got %h want 000000", quot); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL rst_div_zero: got %b want 0", div_zero); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic run_list(input string name, input logic [23:0] av[], input logic [23:0] bv[]);
        exp_t e;
        int   lat;
        for (int i = 0; i < av.size(); i++) begin
            drive_op(av[i], bv[i]);
            wait_result(1, lat);
            e = sb.pop_front();
            checks++; if (quot !== e.q) begin errors++; $display("FAIL %s_quot[%0d]: got %h want %h", name, i, quot, e.q); end
            checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL %s_div_zero[%0d]: got %b want %b", name, i, div_zero, e.dz); end
            checks++; if (ovf !== e.ov) begin errors++; $display("FAIL %s_ovf[%0d]: got %b want %b", name, i, ovf, e.ov); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_normal();
        run_list("normal", '{24'h418000, 24'h3F0000, 24'hC18000, 24'h3F0000},
                           '{24'h408000, 24'h408000, 24'h408000, 24'h400000});
    endtask

    task automatic test_special();
        run_list("special", '{24'h3F0000, 24'h000000, 24'h000000, 24'hBF0000},
                            '{24'h800000, 24'h408000, 24'h000000, 24'h408000});
    endtask

    task automatic test_exponent();
        run_list("exponent", '{24'h7E0000, 24'h010000, 24'hFE0000},
                             '{24'h010000, 24'h7E0000, 24'h010000});
    endtask

    task automatic test_random();
        logic [23:0] av[16];
        logic [23:0] bv[16];
        for (int i = 0; i < 16; i++) begin
            av[i] = {1'($urandom), 7'($urandom_range(1, 127)), 16'($urandom)};
            bv[i] = {1'($urandom), 7'($urandom_range(1, 127)), 16'($urandom)};
        end
        run_list("random", av, bv);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        drive_op(24'h418000, 24'h408000);
        repeat (5) begin @(posedge clk); #1; end
        a = 24'h3F0000;
        b = 24'h400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(7, lat);
        e = sb.pop_front();
        checks++; if (quot !== e.q) begin errors++; $display("FAIL busy_ignore_quot: got %h want %h", quot, e.q); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 20", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (quot !== e.q) begin errors++; $display("FAIL hold_quot[%0d]: got %h want %h", i, quot, e.q); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        a = 24'h3F0000;
        b = 24'h400000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_no_accept: in_ready got %b want 1", in_ready); end
        sb.push_back(model(24'h3F0000, 24'h400000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(1, lat);
        e = sb.pop_front();
        checks++; if (quot !== e.q) begin errors++; $display("FAIL next_accept_quot: got %h want %h", quot, e.q); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL next_accept_latency: got %0d want 20", lat); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_result: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   lat;
        bit   seen = 1'b0;
        drive_op(24'h3F0000, 24'h408000);
        e = sb.pop_back();
        repeat (6) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        #10;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_release_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 25; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_abandoned: stray out_valid seen=%b want 0", seen); end
        drive_op(24'h3F0000, 24'h400000);
        wait_result(1, lat);
        e = sb.pop_front();
        checks++; if (quot !== e.q) begin errors++; $display("FAIL arst_fresh_quot: got %h want %h", quot, e.q); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL arst_fresh_latency: got %0d want 20", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_exponent();
        test_random();
        test_back_to_back();
        test_async_reset();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
